maxnet_host_ctrl: RTL and testbench
===================================

Name: maxnet_host_ctrl

Overview:
Initiator side of the Maxnet start/finish protocol. Accepts four IEEE-754 single-precision activations as a valid/ready word stream and presents them as a1..a4 with eps. It then fires a one-cycle start, waits for finish with a timeout, and returns out and overflow through a valid/ready result port. It sits between the host-side data path and Maxnet_model and replaces the bench-driven stimulus path.

Parameters:
EPS, 32'hBE4CCCCD, value driven on mx_eps (-0.2 in FP32)
TIMEOUT, 1000000, maximum WAIT cycles before the run is abandoned
CNT_W, $clog2(TIMEOUT+1), width of the timeout counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  input word valid
in_ready  out  1  controller can accept an input word
in_data  in  32  FP32 activation; arrival order a1, a2, a3, a4
mx_start  out  1  one-cycle start pulse to the model
mx_eps  out  32  constant EPS
mx_a1..mx_a4  out  32 each  activations, held stable from START until the next load overwrites them
mx_finish  in  1  model done
mx_overflow  in  1  model overflow flag
mx_out  in  32  model result
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_data  out  32  captured mx_out, or 0 on error or timeout
res_overflow  out  1  captured mx_overflow
res_error  out  1  a NaN or Inf input was rejected
res_timeout  out  1  model did not finish within TIMEOUT
busy  out  1  high in START and WAIT

Behaviour:
- Reset values (async, while rst=0): state=IDLE; all outputs 0 except mx_eps=EPS; word count, timeout counter, err flag, armed flag all cleared.
- All outputs are registered, except in_ready = (state==LOAD) and res_valid = (state==RESULT).
- IDLE: move to LOAD next cycle, unconditionally.
- LOAD: a handshake is in_valid & in_ready. Each handshake writes in_data to mx_a[cnt] and increments cnt.
  - If exponent==8'hFF (NaN or Inf), set sticky err. The word is still stored.
  - On the 4th handshake: if err (including the 4th word itself), go to RESULT with res_error=1 and res_data=0, and do not start. Otherwise go to START.
- START: mx_start=1 for exactly this one cycle. Clear the timeout counter and armed. Go to WAIT.
- WAIT: the counter increments every cycle.
  - armed sets on the first cycle mx_finish is sampled 0. A stale high finish from a previous run is ignored until it drops.
  - If armed & mx_finish: capture mx_out to res_data and mx_overflow to res_overflow, then go to RESULT.
  - Otherwise, when counter==TIMEOUT-1: res_timeout=1, res_data=0, go to RESULT.
  - If finish and timeout occur in the same cycle, finish wins.
- RESULT: res_* outputs stay stable while res_valid=1 & res_ready=0. On res_valid & res_ready, go to LOAD the next cycle and clear cnt, err, res_error and res_timeout. res_ready outside RESULT is ignored.
- mx_a1..mx_a4 are never cleared except by reset.
- Reset mid-operation: immediate return to reset values. mx_start drops asynchronously and any in-flight capture is lost. in_ready goes high 2 cycles after rst deasserts (IDLE, then LOAD).
- Throughput: the best case is one run per 4 + 1 + (model latency) + 1 + 1 cycles.

Decomposition:
- Shared package maxnet_pkg holds:
  - state enum {IDLE, LOAD, START, WAIT, RESULT};
  - FP32 constants EXP_MSB=30, EXP_LSB=23, EXP_SPECIAL=8'hFF;
  - default EPS constant 32'hBE4CCCCD.
- One natural sub-module: fp32_is_special, a combinational NaN/Inf classifier. It is reusable by the model's own input checks.

Test Plan:
1. Send 0x40400000, 0x3F800000, 0x40000000, 0x3F000000 back-to-back; the model stub raises finish 20 cycles after start with out=0x40400000, overflow=0 -> mx_start is a single pulse 1 cycle after the 4th handshake; mx_a1..a4 match the words; res_valid rises with res_data=0x40400000, res_error=0, res_timeout=0.
2. in_valid toggled with gaps, and res_ready held low 5 cycles after res_valid -> words are still captured in order; res_data and flags are stable for all 5 cycles; in_ready stays 0 until 1 cycle after the res handshake.
3. Word 2 = 0x7FC00000 (NaN) -> no mx_start is ever issued; after the 4th word, res_valid=1, res_error=1, res_data=0.
4. TIMEOUT=100 and the stub never asserts finish -> res_timeout=1 and res_data=0 exactly 100 cycles after entering WAIT; busy falls at the same time.
5. mx_finish held high at start, dropped 3 cycles into WAIT, raised again at cycle 10 with out=0x3F800000 -> the early high is ignored and the result is captured at cycle 10.
6. rst pulled low mid-WAIT -> all outputs return to reset values without waiting for a clock edge; after release, in_ready=1 on the 2nd clock and a fresh run from scenario 1 completes correctly.

Source files
------------

// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared state encoding and FP32 field constants
// for the Maxnet host-side controller and model checks.
package maxnet_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      RESULT
   } state_t;

   localparam int          EXP_MSB     = 30;
   localparam int          EXP_LSB     = 23;
   localparam logic [7:0]  EXP_SPECIAL = 8'hFF;
   localparam logic [31:0] EPS_DEFAULT = 32'hBE4CCCCD;

endpackage

// File: rtl/maxnet_host_ctrl_fp32_is_special.sv
// fp32_is_special: combinational NaN / Inf classifier on the
// exponent and mantissa fields of an FP32 word.
module fp32_is_special
   import maxnet_pkg::*;
(
   input  logic [EXP_MSB-EXP_LSB:0] i_exp,
   input  logic [EXP_LSB-1:0]       i_man,
   output logic                     o_nan,
   output logic                     o_inf
);

   logic w_exp_max;
   logic w_man_nz;

   assign w_exp_max = (i_exp == EXP_SPECIAL);
   assign w_man_nz  = |i_man;
   assign o_nan     = w_exp_max & w_man_nz;
   assign o_inf     = w_exp_max & ~w_man_nz;

endmodule

// File: rtl/maxnet_host_ctrl.sv
// maxnet_host_ctrl: loads four FP32 activations, pulses start,
// waits for finish with a timeout and returns the model result.
module maxnet_host_ctrl
   import maxnet_pkg::*;
#(
   parameter logic [31:0] EPS     = EPS_DEFAULT,
   parameter int          TIMEOUT = 1000000,
   parameter int          CNT_W   = $clog2(TIMEOUT + 1)
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        mx_start,
   output logic [31:0] mx_eps,
   output logic [31:0] mx_a1,
   output logic [31:0] mx_a2,
   output logic [31:0] mx_a3,
   output logic [31:0] mx_a4,
   input  logic        mx_finish,
   input  logic        mx_overflow,
   input  logic [31:0] mx_out,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_overflow,
   output logic        res_error,
   output logic        res_timeout,
   output logic        busy
);

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_cnt;
   logic             r_err;
   logic             r_armed;
   logic [CNT_W-1:0] r_tcnt;
   logic             w_nan;
   logic             w_inf;
   logic             w_bad;
   logic             w_hs;
   logic             w_last;
   logic             w_fin;
   logic             w_tmo;

   fp32_is_special u_cls (
      .i_exp (in_data[EXP_MSB:EXP_LSB]),
      .i_man (in_data[EXP_LSB-1:0]),
      .o_nan (w_nan),
      .o_inf (w_inf)
   );

   assign w_bad     = w_nan | w_inf;
   assign in_ready  = (r_state == LOAD);
   assign res_valid = (r_state == RESULT);
   assign w_hs      = in_valid & in_ready;
   assign w_last    = w_hs & (r_cnt == 2'd3);
   assign w_fin     = r_armed & mx_finish;
   assign w_tmo     = (r_tcnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = LOAD;
         LOAD:    if (w_last) w_next = (r_err | w_bad) ? RESULT : START;
         START:   w_next = WAIT;
         WAIT:    if (w_fin || w_tmo) w_next = RESULT;
         RESULT:  if (res_ready) w_next = LOAD;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mx_start     <= 1'b0;
         busy         <= 1'b0;
         mx_eps       <= EPS;
         mx_a1        <= '0;
         mx_a2        <= '0;
         mx_a3        <= '0;
         mx_a4        <= '0;
         res_data     <= '0;
         res_overflow <= 1'b0;
         res_error    <= 1'b0;
         res_timeout  <= 1'b0;
         r_cnt        <= '0;
         r_err        <= 1'b0;
         r_armed      <= 1'b0;
         r_tcnt       <= '0;
      end else begin
         mx_start <= (w_next == START);
         busy     <= (w_next == START) || (w_next == WAIT);
         mx_eps   <= EPS;
         unique case (r_state)
            LOAD: if (w_hs) begin
               r_cnt <= r_cnt + 2'd1;
               r_err <= r_err | w_bad;
               unique case (r_cnt)
                  2'd0: mx_a1 <= in_data;
                  2'd1: mx_a2 <= in_data;
                  2'd2: mx_a3 <= in_data;
                  2'd3: mx_a4 <= in_data;
               endcase
               if (w_last && (r_err || w_bad)) begin
                  res_error <= 1'b1;
                  res_data  <= '0;
               end
            end
            START: begin
               r_tcnt  <= '0;
               r_armed <= 1'b0;
            end
            WAIT: begin
               r_tcnt <= r_tcnt + CNT_W'(1);
               // a finish left high by the previous run is ignored until it drops
               if (!mx_finish) r_armed <= 1'b1;
               if (w_fin) begin
                  res_data     <= mx_out;
                  res_overflow <= mx_overflow;
               end else if (w_tmo) begin
                  res_timeout <= 1'b1;
                  res_data    <= '0;
               end
            end
            RESULT: if (res_ready) begin
               r_cnt       <= '0;
               r_err       <= 1'b0;
               res_error   <= 1'b0;
               res_timeout <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_maxnet_host_ctrl.sv
// tb_maxnet_host_ctrl: scenario tasks with inline checks and a
// result scoreboard drained on every res handshake.
module tb_maxnet_host_ctrl;

   localparam int          TMO  = 100;
   localparam logic [31:0] EPSV = 32'hBE4CCCCD;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        mx_start;
   logic [31:0] mx_eps;
   logic [31:0] mx_a1;
   logic [31:0] mx_a2;
   logic [31:0] mx_a3;
   logic [31:0] mx_a4;
   logic        mx_finish;
   logic        mx_overflow;
   logic [31:0] mx_out;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_overflow;
   logic        res_error;
   logic        res_timeout;
   logic        busy;

   typedef struct packed {
      logic [31:0] data;
      logic        ovf;
      logic        err;
      logic        tmo;
   } exp_t;

   exp_t sb[$];
   int   n_cmp   = 0;
   int   n_bad   = 0;
   int   n_start = 0;

   maxnet_host_ctrl #(.TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .mx_start     (mx_start),
      .mx_eps       (mx_eps),
      .mx_a1        (mx_a1),
      .mx_a2        (mx_a2),
      .mx_a3        (mx_a3),
      .mx_a4        (mx_a4),
      .mx_finish    (mx_finish),
      .mx_overflow  (mx_overflow),
      .mx_out       (mx_out),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data),
      .res_overflow (res_overflow),
      .res_error    (res_error),
      .res_timeout  (res_timeout),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (mx_start === 1'b1) n_start++;

   // overflow is only meaningful for a completed run
   always @(negedge clk) begin
      exp_t e;
      if (rst && res_valid && res_ready) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_empty: unexpected result data=%h", res_data);
         end else begin
            e = sb.pop_front();
            if (res_data !== e.data || res_error !== e.err ||
                res_timeout !== e.tmo ||
                (!e.err && !e.tmo && res_overflow !== e.ovf)) begin
               n_bad++;
               $display("FAIL sb_result: got d=%h o=%b e=%b t=%b need d=%h o=%b e=%b t=%b",
                        res_data, res_overflow, res_error, res_timeout,
                        e.data, e.ovf, e.err, e.tmo);
            end
         end
      end
   end

   task automatic send_word(input logic [31:0] d, input int gap);
      int n = 0;
      in_valid = 1'b0;
      repeat (gap) begin
         in_data = $urandom;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL in_ready_wait: in_ready=%b after %0d cycles, need 1", in_ready, n);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_res(output bit ok, output int n);
      n = 0;
      while (!res_valid && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      ok = res_valid;
   endtask

   task automatic ack();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      n_cmp++;
      if ({in_ready, res_valid, mx_start, busy, res_error, res_timeout, res_overflow} !== 7'b0 ||
          res_data !== 32'h0 || {mx_a1, mx_a2, mx_a3, mx_a4} !== 128'h0 || mx_eps !== EPSV) begin
         n_bad++;
         $display("FAIL reset_vals: ctl=%b data=%h a1=%h eps=%h, need 0 0 0 %h",
                  {in_ready, res_valid, mx_start, busy, res_error, res_timeout, res_overflow},
                  res_data, mx_a1, mx_eps, EPSV);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle: in_ready=%b, need 0", in_ready);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_load: in_ready=%b, need 1", in_ready);
      end
   endtask

   task automatic test_basic();
      logic [31:0] w [4] = '{32'h40400000, 32'h3F800000, 32'h40000000, 32'h3F000000};
      int s0;
      int n;
      bit ok;
      s0 = n_start;
      mx_finish = 1'b0;
      sb.push_back('{data: 32'h40400000, ovf: 1'b0, err: 1'b0, tmo: 1'b0});
      for (int i = 0; i < 4; i++) send_word(w[i], 0);
      n_cmp++;
      if (mx_start !== 1'b1 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_start: mx_start=%b busy=%b, need 1 1", mx_start, busy);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (mx_start !== 1'b0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_pulse: mx_start=%b busy=%b, need 0 1", mx_start, busy);
      end
      n_cmp++;
      if ({mx_a1, mx_a2, mx_a3, mx_a4} !== {w[0], w[1], w[2], w[3]} || mx_eps !== EPSV) begin
         n_bad++;
         $display("FAIL basic_words: a=%h %h %h %h eps=%h, need %h %h %h %h %h",
                  mx_a1, mx_a2, mx_a3, mx_a4, mx_eps, w[0], w[1], w[2], w[3], EPSV);
      end
      repeat (19) begin @(posedge clk); #1; end
      mx_out      = 32'h40400000;
      mx_overflow = 1'b0;
      mx_finish   = 1'b1;
      wait_res(ok, n);
      n_cmp++;
      if (!ok || n != 1 || busy !== 1'b0 || n_start - s0 != 1) begin
         n_bad++;
         $display("FAIL basic_result: valid=%b lat=%0d busy=%b starts=%0d, need 1 1 0 1",
                  res_valid, n, busy, n_start - s0);
      end
      ack();
      mx_finish = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_reload: in_ready=%b, need 1", in_ready);
      end
   endtask

   task automatic test_gaps();
      logic [31:0] w [4] = '{32'h3E800000, 32'hC0000000, 32'h41200000, 32'h00000000};
      int g [4] = '{2, 0, 3, 1};
      logic [31:0] d;
      logic [2:0] f;
      int bad;
      int n;
      bit ok;
      sb.push_back('{data: 32'hC1000000, ovf: 1'b1, err: 1'b0, tmo: 1'b0});
      for (int i = 0; i < 4; i++) send_word(w[i], g[i]);
      n_cmp++;
      if (mx_start !== 1'b1 || {mx_a1, mx_a2, mx_a3, mx_a4} !== {w[0], w[1], w[2], w[3]}) begin
         n_bad++;
         $display("FAIL gaps_words: start=%b a=%h %h %h %h, need 1 %h %h %h %h",
                  mx_start, mx_a1, mx_a2, mx_a3, mx_a4, w[0], w[1], w[2], w[3]);
      end
      repeat (5) begin @(posedge clk); #1; end
      mx_out      = 32'hC1000000;
      mx_overflow = 1'b1;
      mx_finish   = 1'b1;
      wait_res(ok, n);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL gaps_res_wait: res_valid=%b after %0d cycles, need 1", res_valid, n);
      end
      d   = res_data;
      f   = {res_overflow, res_error, res_timeout};
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (res_valid !== 1'b1 || res_data !== d || in_ready !== 1'b0 ||
             {res_overflow, res_error, res_timeout} !== f) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL gaps_hold: %0d unstable cycles, need 0", bad);
      end
      ack();
      mx_finish = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL gaps_release: in_ready=%b res_valid=%b, need 1 0", in_ready, res_valid);
      end
   endtask

   task automatic test_error();
      logic [31:0] w1 [4] = '{32'h3F800000, 32'h7FC00000, 32'h40000000, 32'h40400000};
      logic [31:0] w2 [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h7F800000};
      int s0;
      s0 = n_start;
      sb.push_back('{data: 32'h0, ovf: 1'b0, err: 1'b1, tmo: 1'b0});
      for (int i = 0; i < 4; i++) send_word(w1[i], 0);
      n_cmp++;
      if (res_valid !== 1'b1 || res_error !== 1'b1 || res_data !== 32'h0 ||
          res_timeout !== 1'b0 || in_ready !== 1'b0 || mx_start !== 1'b0) begin
         n_bad++;
         $display("FAIL nan_result: v=%b e=%b d=%h t=%b rdy=%b st=%b, need 1 1 0 0 0 0",
                  res_valid, res_error, res_data, res_timeout, in_ready, mx_start);
      end
      n_cmp++;
      if (mx_a2 !== 32'h7FC00000) begin
         n_bad++;
         $display("FAIL nan_stored: a2=%h, need 7fc00000", mx_a2);
      end
      ack();
      n_cmp++;
      if (res_error !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL nan_clear: res_error=%b in_ready=%b, need 0 1", res_error, in_ready);
      end
      sb.push_back('{data: 32'h0, ovf: 1'b0, err: 1'b1, tmo: 1'b0});
      for (int i = 0; i < 4; i++) send_word(w2[i], 0);
      n_cmp++;
      if (res_valid !== 1'b1 || res_error !== 1'b1 || mx_a4 !== 32'h7F800000) begin
         n_bad++;
         $display("FAIL inf_last: v=%b e=%b a4=%h, need 1 1 7f800000",
                  res_valid, res_error, mx_a4);
      end
      ack();
      n_cmp++;
      if (n_start != s0) begin
         n_bad++;
         $display("FAIL err_nostart: starts=%0d, need 0", n_start - s0);
      end
   endtask

   task automatic test_stale_finish();
      int bad;
      mx_finish   = 1'b1;
      mx_out      = 32'h12345678;
      mx_overflow = 1'b1;
      sb.push_back('{data: 32'h3F800000, ovf: 1'b0, err: 1'b0, tmo: 1'b0});
      for (int i = 0; i < 4; i++) send_word(32'h3F000000 + i, 0);
      @(posedge clk); #1;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         if (c == 3) mx_finish = 1'b0;
         if (res_valid !== 1'b0 || busy !== 1'b1) bad++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (bad != 0 || res_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL stale_ignored: %0d early-result cycles, need 0", bad);
      end
      mx_out      = 32'h3F800000;
      mx_overflow = 1'b0;
      mx_finish   = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (res_valid !== 1'b1 || res_data !== 32'h3F800000 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL stale_capture: v=%b d=%h busy=%b, need 1 3f800000 0",
                  res_valid, res_data, busy);
      end
      ack();
      mx_finish = 1'b0;
   endtask

   task automatic test_timeout();
      int s0;
      int bad;
      s0 = n_start;
      mx_finish = 1'b0;
      sb.push_back('{data: 32'h0, ovf: 1'b0, err: 1'b0, tmo: 1'b1});
      send_word(32'h3DCCCCCD, 0);
      send_word(32'h40490FDB, 0);
      send_word(32'hBF800000, 0);
      send_word(32'h42C80000, 0);
      @(posedge clk); #1;
      bad = 0;
      for (int c = 0; c < TMO; c++) begin
         if (res_valid !== 1'b0 || busy !== 1'b1) bad++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL tmo_early: %0d cycles left WAIT early, need 0", bad);
      end
      n_cmp++;
      if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_data !== 32'h0 ||
          busy !== 1'b0 || n_start - s0 != 1) begin
         n_bad++;
         $display("FAIL tmo_result: v=%b t=%b d=%h busy=%b starts=%0d, need 1 1 0 0 1",
                  res_valid, res_timeout, res_data, busy, n_start - s0);
      end
      ack();
      n_cmp++;
      if (res_timeout !== 1'b0) begin
         n_bad++;
         $display("FAIL tmo_clear: res_timeout=%b, need 0", res_timeout);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) send_word(32'h40800000 + i, 0);
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (mx_start !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_start_async: mx_start=%b busy=%b, need 0 0", mx_start, busy);
      end
      #2 rst = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) send_word(32'h41000000 + i, 0);
      repeat (5) begin @(posedge clk); #1; end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if ({in_ready, res_valid, mx_start, busy, res_error, res_timeout, res_overflow} !== 7'b0 ||
          res_data !== 32'h0 || {mx_a1, mx_a2, mx_a3, mx_a4} !== 128'h0 || mx_eps !== EPSV) begin
         n_bad++;
         $display("FAIL rst_wait_async: ctl=%b d=%h a1=%h eps=%h, need 0 0 0 %h",
                  {in_ready, res_valid, mx_start, busy, res_error, res_timeout, res_overflow},
                  res_data, mx_a1, mx_eps, EPSV);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_release_idle: in_ready=%b, need 0", in_ready);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_release_load: in_ready=%b, need 1", in_ready);
      end
      test_basic();
   endtask

   initial begin
      rst         = 1'b0;
      in_valid    = 1'b0;
      in_data     = 32'h0;
      mx_finish   = 1'b0;
      mx_overflow = 1'b0;
      mx_out      = 32'h0;
      res_ready   = 1'b0;
      test_reset();
      test_basic();
      test_gaps();
      test_error();
      test_stale_finish();
      test_timeout();
      test_reset_mid();
      repeat (3) @(posedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain: %0d results never produced, need 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, need completion");
      $fatal(1);
   end

endmodule
